audio_dac_tx: RTL and testbench

- Responder for the audio write handshake: the design asserts write while write_ready is high, and this block accepts {left,right} sample pairs into a small FIFO.
- Serializes each pair onto AUD_DACDAT in I2S format, framed by codec-driven AUD_BCLK and AUD_DACLRCK, which are sampled in the clk domain.
- Transmit-side counterpart of the codec ADC read path; sits between the sample-select mux and the WM8731 DAC pins.

---
 rtl/audio_dac_tx.sv | 178 +++++++++++++++++
 tb/tb_audio_dac_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_tx.sv
// audio_dac_tx -- I2S transmit path toward the WM8731 DAC.
//   Accepts {left,right} sample pairs through a write/write_ready handshake into
//   a small FIFO. Each pair is shifted MSB-first onto AUD_DACDAT in I2S format,
//   framed by the codec-driven AUD_BCLK / AUD_DACLRCK. Both are sampled into the
//   clk domain before their edges are detected.
// Ports:
//   clk, reset_n                      system clock, asynchronous active-low reset
//   write, writedata_left/right       push request and signed sample pair
//   write_ready                       FIFO not full (combinational from count)
//   AUD_BCLK, AUD_DACLRCK             codec bit / frame clocks (asynchronous)
//   AUD_DACDAT                        registered serial data to the DAC
//   underflow_count                   frames started with an empty FIFO (saturating)
//   active                            a frame has started since reset
module audio_dac_tx #(
   parameter int DATA_WIDTH  = 24,
   parameter int FIFO_DEPTH  = 4,
   parameter int UFLOW_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   write,
   input  logic [DATA_WIDTH-1:0]  writedata_left,
   input  logic [DATA_WIDTH-1:0]  writedata_right,
   output logic                   write_ready,
   input  logic                   AUD_BCLK,
   input  logic                   AUD_DACLRCK,
   output logic                   AUD_DACDAT,
   output logic [UFLOW_WIDTH-1:0] underflow_count,
   output logic                   active
);

   typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, SHIFT = 2'd2, PAD = 2'd3} state_t;

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
   localparam int PAIR_W = 2 * DATA_WIDTH;

   logic                   bclk_meta_r, bclk_sync_r, bclk_hist_r;
   logic                   lr_meta_r, lr_sync_r, lr_hist_r;
   logic                   bclk_fall_s, lr_fall_s, lr_rise_s;

   logic [PAIR_W-1:0]      fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]       count_r;
   logic                   push_s, pop_s, empty_s;

   state_t                 state_r;
   logic [DATA_WIDTH-1:0]  left_r, right_r, shreg_r, chan_s;
   logic [BIT_W-1:0]       sent_r;
   logic                   dacdat_r, active_r;
   logic [UFLOW_WIDTH-1:0] uflow_r;

   // Two-flop synchronizers plus one history flop per codec clock.
   // Everything resets to 0 so that a low pin at release can never look like a
   // falling edge and start a partial frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_meta_r <= 1'b0;
         bclk_sync_r <= 1'b0;
         bclk_hist_r <= 1'b0;
         lr_meta_r   <= 1'b0;
         lr_sync_r   <= 1'b0;
         lr_hist_r   <= 1'b0;
      end else begin
         bclk_meta_r <= AUD_BCLK;
         bclk_sync_r <= bclk_meta_r;
         bclk_hist_r <= bclk_sync_r;
         lr_meta_r   <= AUD_DACLRCK;
         lr_sync_r   <= lr_meta_r;
         lr_hist_r   <= lr_sync_r;
      end
   end

   // Edge detection, FIFO handshake and channel selection.
   always_comb begin
      bclk_fall_s = bclk_hist_r & ~bclk_sync_r;
      lr_fall_s   = lr_hist_r & ~lr_sync_r;
      lr_rise_s   = ~lr_hist_r & lr_sync_r;
      write_ready = (count_r != CNT_W'(FIFO_DEPTH));
      empty_s     = (count_r == CNT_W'(0));
      push_s      = write & write_ready;
      // Every frame start consumes one entry when there is one.
      pop_s       = lr_fall_s & ~empty_s;
      chan_s      = lr_sync_r ? right_r : left_r;
   end

   // FIFO storage; contents are qualified by count, so they need no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= {writedata_left, writedata_right};
      end
   end

   // FIFO pointers and occupancy; push and pop in one cycle leave count alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Serializer state machine. LR edges take priority over a bit-clock edge
   // seen in the same cycle; that bit-clock edge then serves as the delay slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= IDLE;
         left_r   <= '0;
         right_r  <= '0;
         shreg_r  <= '0;
         sent_r   <= BIT_W'(0);
         dacdat_r <= 1'b0;
         active_r <= 1'b0;
         uflow_r  <= UFLOW_WIDTH'(0);
      end else if (lr_fall_s) begin
         state_r  <= DELAY;
         active_r <= 1'b1;
         if (empty_s) begin
            left_r  <= '0;
            right_r <= '0;
            if (uflow_r != {UFLOW_WIDTH{1'b1}}) begin
               uflow_r <= uflow_r + UFLOW_WIDTH'(1);
            end
         end else begin
            {left_r, right_r} <= fifo_mem_r[rd_ptr_r];
         end
      end else if (lr_rise_s && (state_r != IDLE)) begin
         state_r <= DELAY;
      end else if (bclk_fall_s) begin
         case (state_r)
            IDLE: begin
               dacdat_r <= 1'b0;
            end
            DELAY: begin
               dacdat_r <= chan_s[DATA_WIDTH-1];
               shreg_r  <= {chan_s[DATA_WIDTH-2:0], 1'b0};
               sent_r   <= BIT_W'(1);
               state_r  <= SHIFT;
            end
            SHIFT: begin
               if (sent_r == BIT_W'(DATA_WIDTH)) begin
                  dacdat_r <= 1'b0;
                  state_r  <= PAD;
               end else begin
                  dacdat_r <= shreg_r[DATA_WIDTH-1];
                  shreg_r  <= {shreg_r[DATA_WIDTH-2:0], 1'b0};
                  sent_r   <= sent_r + BIT_W'(1);
               end
            end
            PAD: begin
               dacdat_r <= 1'b0;
            end
            default: begin
               dacdat_r <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   assign AUD_DACDAT      = dacdat_r;
   assign underflow_count = uflow_r;
   assign active          = active_r;

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx -- self-checking bench for audio_dac_tx.
//   Acts as the codec (BCLK = 16 clk, LRCK edges on BCLK falls), samples
//   AUD_DACDAT at each BCLK rise, and compares against a queue-based model
//   of the FIFO and the I2S slot layout.
module tb_audio_dac_tx;

   logic        clk;
   logic        reset_n;
   logic        write;
   logic [23:0] wl, wr;
   logic        ready;
   logic        bclk, lrck;
   logic        dacdat;
   logic [7:0]  uflow;
   logic        act;

   int          n_cmp;
   int          n_fail;
   logic [47:0] mq [$];
   int          m_uflow;

   audio_dac_tx #(.DATA_WIDTH(24), .FIFO_DEPTH(4), .UFLOW_WIDTH(8)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .write           (write),
      .writedata_left  (wl),
      .writedata_right (wr),
      .write_ready     (ready),
      .AUD_BCLK        (bclk),
      .AUD_DACLRCK     (lrck),
      .AUD_DACDAT      (dacdat),
      .underflow_count (uflow),
      .active          (act)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected slot pattern of one channel: slot 0 is the delay slot, then the
   // sample MSB-first, then zeros; bits beyond the channel length are dropped.
   function automatic logic [63:0] exp_bits(input logic [23:0] d, input int slots);
      logic [63:0] e;
      e = '0;
      for (int s = 1; s < slots; s++) begin
         if (s <= 24) e[s] = d[24 - s];
      end
      return e;
   endfunction

   function automatic logic [63:0] slot_mask(input int slots);
      logic [63:0] m;
      m = '0;
      for (int s = 1; s < slots; s++) m[s] = 1'b1;
      return m;
   endfunction

   // Frame start in the model: oldest pair, or silence and one more underflow.
   function automatic logic [47:0] model_pop();
      if (mq.size() > 0) return mq.pop_front();
      if (m_uflow < 255) m_uflow++;
      return 48'd0;
   endfunction

   task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
      @(negedge clk);
      write = 1'b1;
      wl = l;
      wr = r;
      if (mq.size() < 4) mq.push_back({l, r});
   endtask

   task automatic push_end();
      @(negedge clk);
      write = 1'b0;
   endtask

   // One BCLK period: fall (with LRCK update) then rise, sampling DACDAT at the rise.
   task automatic bclk_slot(input logic lr, output logic b);
      @(negedge clk);
      bclk = 1'b0;
      lrck = lr;
      repeat (8) @(negedge clk);
      bclk = 1'b1;
      b = dacdat;
      repeat (7) @(negedge clk);
   endtask

   task automatic run_frame(input int slots, output logic [63:0] lc, output logic [63:0] rc);
      logic b;
      lc = '0;
      rc = '0;
      for (int s = 0; s < slots; s++) begin
         bclk_slot(1'b0, b);
         lc[s] = b;
      end
      for (int s = 0; s < slots; s++) begin
         bclk_slot(1'b1, b);
         rc[s] = b;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      write = 1'b0;
      wl = 24'd0;
      wr = 24'd0;
      bclk = 1'b1;
      lrck = 1'b1;
      mq.delete();
      m_uflow = 0;
      repeat (3) @(negedge clk);
      n_cmp++; if (dacdat !== 1'b0) begin n_fail++; $display("FAIL reset_dacdat: got %b expected 0", dacdat); end
      n_cmp++; if (uflow !== 8'd0) begin n_fail++; $display("FAIL reset_uflow: got %0d expected 0", uflow); end
      n_cmp++; if (act !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", act); end
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
   endtask

   task automatic test_basic();
      logic [63:0] lc, rc;
      logic [47:0] p;
      push_pair(24'hA5A5A5, 24'h123456);
      push_end();
      n_cmp++; if (act !== 1'b0) begin n_fail++; $display("FAIL basic_idle_active: got %b expected 0", act); end
      p = model_pop();
      run_frame(32, lc, rc);
      n_cmp++; if ((lc & slot_mask(32)) !== exp_bits(p[47:24], 32)) begin n_fail++; $display("FAIL basic_left: got %h expected %h", lc & slot_mask(32), exp_bits(p[47:24], 32)); end
      n_cmp++; if ((rc & slot_mask(32)) !== exp_bits(p[23:0], 32)) begin n_fail++; $display("FAIL basic_right: got %h expected %h", rc & slot_mask(32), exp_bits(p[23:0], 32)); end
      n_cmp++; if (lc[0] !== 1'b0) begin n_fail++; $display("FAIL basic_first_delay: got %b expected 0", lc[0]); end
      n_cmp++; if (uflow !== 8'd0) begin n_fail++; $display("FAIL basic_uflow: got %0d expected 0", uflow); end
      n_cmp++; if (act !== 1'b1) begin n_fail++; $display("FAIL basic_active: got %b expected 1", act); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] lc, rc;
      logic [47:0] p;
      logic        er;
      for (int i = 0; i < 5; i++) begin
         er = (mq.size() != 4);
         push_pair(24'($urandom), 24'($urandom));
         n_cmp++; if (ready !== er) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected %b", i, ready, er); end
      end
      push_end();
      n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b expected 0", ready); end
      for (int f = 0; f < 4; f++) begin
         p = model_pop();
         run_frame(32, lc, rc);
         n_cmp++; if ((lc & slot_mask(32)) !== exp_bits(p[47:24], 32)) begin n_fail++; $display("FAIL b2b_left%0d: got %h expected %h", f, lc & slot_mask(32), exp_bits(p[47:24], 32)); end
         n_cmp++; if ((rc & slot_mask(32)) !== exp_bits(p[23:0], 32)) begin n_fail++; $display("FAIL b2b_right%0d: got %h expected %h", f, rc & slot_mask(32), exp_bits(p[23:0], 32)); end
      end
      n_cmp++; if (uflow !== 8'(m_uflow)) begin n_fail++; $display("FAIL b2b_uflow: got %0d expected %0d", uflow, m_uflow); end
   endtask

   task automatic test_full_pop_push();
      logic [63:0] lc, rc;
      logic [47:0] p;
      for (int i = 0; i < 4; i++) push_pair(24'($urandom), 24'($urandom));
      push_end();
      n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL fpp_full: got %b expected 0", ready); end
      p = model_pop();
      fork
         run_frame(32, lc, rc);
         begin
            // LRCK falls at the first negedge; the pop lands after the third.
            repeat (3) @(negedge clk);
            n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL fpp_prepop_ready: got %b expected 0", ready); end
            write = 1'b1;
            wl = 24'hDEAD00;
            wr = 24'h00BEEF;
            @(negedge clk);
            write = 1'b0;
            n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL fpp_postpop_ready: got %b expected 1", ready); end
         end
      join
      n_cmp++; if ((lc & slot_mask(32)) !== exp_bits(p[47:24], 32)) begin n_fail++; $display("FAIL fpp_left: got %h expected %h", lc & slot_mask(32), exp_bits(p[47:24], 32)); end
      push_pair(24'($urandom), 24'($urandom));
      push_end();
      n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL fpp_refill: got %b expected 0", ready); end
      for (int f = 0; f < 4; f++) begin
         p = model_pop();
         run_frame(32, lc, rc);
         n_cmp++; if ((lc & slot_mask(32)) !== exp_bits(p[47:24], 32)) begin n_fail++; $display("FAIL fpp_left%0d: got %h expected %h", f, lc & slot_mask(32), exp_bits(p[47:24], 32)); end
         n_cmp++; if ((rc & slot_mask(32)) !== exp_bits(p[23:0], 32)) begin n_fail++; $display("FAIL fpp_right%0d: got %h expected %h", f, rc & slot_mask(32), exp_bits(p[23:0], 32)); end
      end
   endtask

   task automatic test_short_frame();
      logic [63:0] lc, rc;
      logic [47:0] p;
      for (int i = 0; i < 3; i++) push_pair(24'($urandom), 24'($urandom));
      push_end();
      for (int f = 0; f < 3; f++) begin
         p = model_pop();
         run_frame(20, lc, rc);
         n_cmp++; if ((lc & slot_mask(20)) !== exp_bits(p[47:24], 20)) begin n_fail++; $display("FAIL short_left%0d: got %h expected %h", f, lc & slot_mask(20), exp_bits(p[47:24], 20)); end
         n_cmp++; if ((rc & slot_mask(20)) !== exp_bits(p[23:0], 20)) begin n_fail++; $display("FAIL short_right%0d: got %h expected %h", f, rc & slot_mask(20), exp_bits(p[23:0], 20)); end
      end
      push_pair(24'($urandom), 24'($urandom));
      push_end();
      p = model_pop();
      run_frame(32, lc, rc);
      n_cmp++; if ((lc & slot_mask(32)) !== exp_bits(p[47:24], 32)) begin n_fail++; $display("FAIL short_after_left: got %h expected %h", lc & slot_mask(32), exp_bits(p[47:24], 32)); end
      n_cmp++; if ((rc & slot_mask(32)) !== exp_bits(p[23:0], 32)) begin n_fail++; $display("FAIL short_after_right: got %h expected %h", rc & slot_mask(32), exp_bits(p[23:0], 32)); end
   endtask

   task automatic test_random();
      logic [63:0] lc, rc;
      logic [47:0] p;
      logic        er;
      int          k, nf, sl;
      for (int it = 0; it < 4; it++) begin
         k = $urandom_range(0, 5);
         for (int i = 0; i < k; i++) begin
            er = (mq.size() != 4);
            push_pair(24'($urandom), 24'($urandom));
            n_cmp++; if (ready !== er) begin n_fail++; $display("FAIL rnd_ready%0d_%0d: got %b expected %b", it, i, ready, er); end
         end
         push_end();
         nf = $urandom_range(1, 2);
         for (int f = 0; f < nf; f++) begin
            sl = $urandom_range(20, 32);
            p = model_pop();
            run_frame(sl, lc, rc);
            n_cmp++; if ((lc & slot_mask(sl)) !== exp_bits(p[47:24], sl)) begin n_fail++; $display("FAIL rnd_left%0d_%0d: got %h expected %h", it, f, lc & slot_mask(sl), exp_bits(p[47:24], sl)); end
            n_cmp++; if ((rc & slot_mask(sl)) !== exp_bits(p[23:0], sl)) begin n_fail++; $display("FAIL rnd_right%0d_%0d: got %h expected %h", it, f, rc & slot_mask(sl), exp_bits(p[23:0], sl)); end
         end
         n_cmp++; if (uflow !== 8'(m_uflow)) begin n_fail++; $display("FAIL rnd_uflow%0d: got %0d expected %0d", it, uflow, m_uflow); end
      end
   endtask

   task automatic test_underflow();
      logic [63:0] lc, rc;
      logic [47:0] p;
      int          base;
      while (mq.size() > 0) begin
         p = model_pop();
         run_frame(32, lc, rc);
         n_cmp++; if ((lc & slot_mask(32)) !== exp_bits(p[47:24], 32)) begin n_fail++; $display("FAIL drain_left: got %h expected %h", lc & slot_mask(32), exp_bits(p[47:24], 32)); end
      end
      base = m_uflow;
      for (int f = 0; f < 3; f++) begin
         p = model_pop();
         run_frame(32, lc, rc);
         n_cmp++; if ((lc | rc) !== 64'd0) begin n_fail++; $display("FAIL uflow_zero%0d: got %h/%h expected 0", f, lc, rc); end
      end
      n_cmp++; if (uflow !== 8'(base + 3)) begin n_fail++; $display("FAIL uflow_three: got %0d expected %0d", uflow, base + 3); end
      for (int f = 0; f < 300; f++) begin
         p = model_pop();
         run_frame(2, lc, rc);
         if (f == 248) begin
            n_cmp++; if (uflow !== 8'(m_uflow)) begin n_fail++; $display("FAIL uflow_near_sat: got %0d expected %0d", uflow, m_uflow); end
         end
      end
      n_cmp++; if (uflow !== 8'd255) begin n_fail++; $display("FAIL uflow_sat: got %0d expected 255", uflow); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] lc, rc;
      logic [47:0] p;
      logic        b, any;
      push_pair(24'hFFFFFF, 24'($urandom));
      push_pair(24'($urandom), 24'($urandom));
      push_end();
      p = model_pop();
      for (int s = 0; s < 5; s++) bclk_slot(1'b0, b);
      @(negedge clk);
      bclk = 1'b0;
      repeat (8) @(negedge clk);
      bclk = 1'b1;
      n_cmp++; if (dacdat !== 1'b1) begin n_fail++; $display("FAIL mid_before: got %b expected 1", dacdat); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (dacdat !== 1'b0) begin n_fail++; $display("FAIL mid_async_dacdat: got %b expected 0", dacdat); end
      n_cmp++; if (act !== 1'b0) begin n_fail++; $display("FAIL mid_active: got %b expected 0", act); end
      n_cmp++; if (uflow !== 8'd0) begin n_fail++; $display("FAIL mid_uflow: got %0d expected 0", uflow); end
      mq.delete();
      m_uflow = 0;
      repeat (7) @(negedge clk);
      reset_n = 1'b1;
      any = 1'b0;
      for (int s = 6; s < 32; s++) begin bclk_slot(1'b0, b); any = any | b; end
      for (int s = 0; s < 32; s++) begin bclk_slot(1'b1, b); any = any | b; end
      n_cmp++; if (any !== 1'b0) begin n_fail++; $display("FAIL mid_silent: got %b expected 0", any); end
      push_pair(24'($urandom), 24'($urandom));
      push_end();
      p = model_pop();
      run_frame(32, lc, rc);
      n_cmp++; if ((lc & slot_mask(32)) !== exp_bits(p[47:24], 32)) begin n_fail++; $display("FAIL mid_resume_left: got %h expected %h", lc & slot_mask(32), exp_bits(p[47:24], 32)); end
      n_cmp++; if ((rc & slot_mask(32)) !== exp_bits(p[23:0], 32)) begin n_fail++; $display("FAIL mid_resume_right: got %h expected %h", rc & slot_mask(32), exp_bits(p[23:0], 32)); end
      n_cmp++; if (uflow !== 8'd0) begin n_fail++; $display("FAIL mid_resume_uflow: got %0d expected 0", uflow); end
      n_cmp++; if (act !== 1'b1) begin n_fail++; $display("FAIL mid_resume_active: got %b expected 1", act); end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_full_pop_push();
      test_short_frame();
      test_random();
      test_underflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
